// File: rtl/pattern_tx_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : pattern_tx_pkg                                         |
// | Description : Shared constants, state encodings and helpers for the  |
// |               pattern serializer transmitter.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package pattern_tx_pkg;

  // Default build configuration of the transmitter
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_LEN_W = 4;
  localparam int DEFAULT_GAP   = 1;

  // Run length the downstream detector looks for
  localparam int RUN_LEN = 3;

  // Transmitter states
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  // A requested length of 0, or one beyond the word width, means a full word
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_run_model.sv
// +----------------------------------------------------------------------+
// | Module      : pattern_run_model                                      |
// | Description : Tracks the transmitted bit stream and counts every     |
// |               cycle that completes a run of RUN_LEN ones             |
// |               (overlapping), saturating at 16'hFFFF.                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module pattern_run_model
  import pattern_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_valid_i,
  input  logic        bit_i,
  output logic [15:0] count_o
);

  // One flag per previous valid bit; all ones means the prior bits were all 1
  logic [RUN_LEN-2:0] r_hist;
  logic [15:0]        r_count;

  // History shifts in ones, clears on a valid zero; idle cycles leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_count <= '0;
    end else if (bit_valid_i) begin
      if (bit_i) begin
        r_hist <= {r_hist[RUN_LEN-3:0], 1'b1};
        if ((&r_hist) && (r_count != 16'hFFFF)) begin
          r_count <= r_count + 16'd1;
        end
      end else begin
        r_hist <= '0;
      end
    end
  end

  assign count_o = r_count;

endmodule

`default_nettype wire

// File: rtl/pattern_serializer_tx.sv
// +----------------------------------------------------------------------+
// | Module      : pattern_serializer_tx                                  |
// | Description : Parallel-to-serial pattern transmitter. Accepts a word |
// |               over valid/ready and shifts data_i[len-1:0] out MSB    |
// |               first, followed by GAP zero bits.                      |
// |               Optional macro PATTERN_TX_EXPECT_EN builds a run-of-   |
// |               three ones counter on the outgoing stream.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module pattern_serializer_tx
  import pattern_tx_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEN_W = DEFAULT_LEN_W,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      expect_cnt_o
);

  // Gap counter is at least one bit wide even when no gap is configured
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0] c_gap_last = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [LEN_W-1:0] c_width    = LEN_W'(WIDTH);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [LEN_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_bit;
  logic             r_valid;
  logic             r_done;

  logic [LEN_W-1:0] w_len_eff;
  logic [WIDTH-1:0] w_aligned;
  logic             w_last_bit;
  logic             w_last_gap;
  logic             w_ready;
  logic             w_accept;

  // Left-align the selected field so the next bit is always at the MSB;
  // bits above the field fall off the top of the word.
  assign w_len_eff  = LEN_W'(clamp_len(32'(len_i), 32'(WIDTH)));
  assign w_aligned  = data_i << (c_width - w_len_eff);

  assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == '0);
  assign w_last_gap = (r_state == ST_GAP) && (r_gap_cnt == '0);

  // Ready in the final cycle of a word lets the next word follow with no bubble
  assign w_ready  = rst_n && ((r_state == ST_IDLE) ||
                              (w_last_bit && (GAP == 0)) ||
                              (w_last_gap && (GAP > 0)));
  assign w_accept = valid_i && w_ready;

  // Main sequencer: load on accept, shift one bit per cycle, then pad the gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_gap_cnt <= '0;
      r_bit     <= 1'b0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_SHIFT;
      r_bit   <= w_aligned[WIDTH-1];
      r_shift <= w_aligned << 1;
      r_cnt   <= w_len_eff - LEN_W'(1);
      r_done  <= (w_len_eff == LEN_W'(1));
      r_valid <= 1'b1;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (r_cnt != '0) begin
            r_bit   <= r_shift[WIDTH-1];
            r_shift <= r_shift << 1;
            r_cnt   <= r_cnt - LEN_W'(1);
            r_done  <= (r_cnt == LEN_W'(1));
          end else if (GAP > 0) begin
            r_state   <= ST_GAP;
            r_bit     <= 1'b0;
            r_done    <= 1'b0;
            r_gap_cnt <= c_gap_last;
          end else begin
            r_state <= ST_IDLE;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_bit   <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = w_ready;
  assign bit_o       = r_bit;
  assign bit_valid_o = r_valid;
  assign done_o      = r_done;
  assign busy_o      = (r_state != ST_IDLE);

`ifdef PATTERN_TX_EXPECT_EN
  pattern_run_model u_run_model (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_valid_i (r_valid),
    .bit_i       (r_bit),
    .count_o     (expect_cnt_o)
  );
`else
  assign expect_cnt_o = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pattern_serializer_tx.sv
// +----------------------------------------------------------------------+
// | Module      : tb_pattern_serializer_tx                               |
// | Description : Directed self-checking bench for pattern_serializer_tx |
// |               with one GAP=1 instance and one GAP=0 instance.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_pattern_serializer_tx;

`ifdef PATTERN_TX_EXPECT_EN
  localparam bit EXP_EN = 1'b1;
`else
  localparam bit EXP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  // GAP=1 instance
  logic        rst_n, valid, ready, bit_out, bit_valid, busy, done;
  logic [7:0]  data;
  logic [3:0]  len;
  logic [15:0] exp_cnt;
  // GAP=0 instance
  logic        rst0_n, valid0, ready0, bit0, bit_valid0, busy0, done0;
  logic [7:0]  data0;
  logic [3:0]  len0;
  logic [15:0] exp_cnt0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pattern_serializer_tx #(.WIDTH(8), .LEN_W(4), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data), .len_i(len), .valid_i(valid),
    .ready_o(ready), .bit_o(bit_out), .bit_valid_o(bit_valid), .busy_o(busy),
    .done_o(done), .expect_cnt_o(exp_cnt)
  );

  pattern_serializer_tx #(.WIDTH(8), .LEN_W(4), .GAP(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .data_i(data0), .len_i(len0), .valid_i(valid0),
    .ready_o(ready0), .bit_o(bit0), .bit_valid_o(bit_valid0), .busy_o(busy0),
    .done_o(done0), .expect_cnt_o(exp_cnt0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pat;
    logic [15:0] stream;

    rst_n = 1'b0; rst0_n = 1'b0;
    valid = 1'b0; data = '0; len = '0;
    valid0 = 1'b0; data0 = '0; len0 = '0;
    #2;
    // Reset state
    check("rst_ready", ready, 0);
    check("rst_bit", bit_out, 0);
    check("rst_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", exp_cnt, 0);
    tick(); tick();
    rst_n = 1'b1; rst0_n = 1'b1;
    tick();
    check("idle_ready", ready, 1);
    check("idle_busy", busy, 0);

    // Word 0xB5, len 0 -> full 8 bits then one gap bit
    pat = 8'hB5;
    data = pat; len = 4'd0; valid = 1'b1;
    tick();
    valid = 1'b0; data = 8'h00; len = 4'd2;
    check("b5_ready_shift", ready, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b5_bit%0d", i), bit_out, pat[7-i]);
      check($sformatf("b5_valid%0d", i), bit_valid, 1);
      check($sformatf("b5_done%0d", i), done, (i == 7));
      tick();
    end
    check("b5_gap_bit", bit_out, 0);
    check("b5_gap_valid", bit_valid, 1);
    check("b5_gap_ready", ready, 1);
    check("b5_gap_done", done, 0);
    tick();
    check("b5_idle_valid", bit_valid, 0);
    check("b5_idle_busy", busy, 0);

    // len 3 of 0xFF -> three ones then gap
    data = 8'hFF; len = 4'd3; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ff3_bit%0d", i), bit_out, 1);
      check($sformatf("ff3_done%0d", i), done, (i == 2));
      tick();
    end
    check("ff3_gap_bit", bit_out, 0);
    check("ff3_gap_valid", bit_valid, 1);
    tick();
    check("ff3_cnt", exp_cnt, EXP_EN ? 1 : 0);

    // len 12 clamps to 8
    pat = 8'hA5;
    data = pat; len = 4'd12; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("clamp_bit%0d", i), bit_out, pat[7-i]);
      check($sformatf("clamp_done%0d", i), done, (i == 7));
      tick();
    end
    check("clamp_gap_bit", bit_out, 0);
    check("clamp_gap_valid", bit_valid, 1);
    tick();

    // len 1 -> single bit with done in the same cycle
    data = 8'h01; len = 4'd1; valid = 1'b1;
    tick();
    valid = 1'b0;
    check("len1_bit", bit_out, 1);
    check("len1_valid", bit_valid, 1);
    check("len1_done", done, 1);
    tick();
    check("len1_gap_bit", bit_out, 0);
    check("len1_gap_valid", bit_valid, 1);
    check("len1_gap_done", done, 0);
    tick();
    check("len1_cnt", exp_cnt, EXP_EN ? 1 : 0);

    // Reset during the 4th bit of 0xF3
    data = 8'hF3; len = 4'd8; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("abort_bit%0d", i), bit_out, 1);
      tick();
    end
    check("abort_bit3_pre", bit_out, 1);
    rst_n = 1'b0;
    #1;
    check("abort_bit", bit_out, 0);
    check("abort_valid", bit_valid, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready, 0);
    check("abort_cnt", exp_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", ready, 1);
    check("post_rst_valid", bit_valid, 0);
    pat = 8'h96;
    data = pat; len = 4'd8; valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fresh_bit%0d", i), bit_out, pat[7-i]);
      check($sformatf("fresh_done%0d", i), done, (i == 7));
      tick();
    end
    check("fresh_gap_valid", bit_valid, 1);
    tick();

    // GAP=0: back-to-back 0xF0 then 0x0F with valid held high
    stream = 16'hF00F;
    data0 = 8'hF0; len0 = 4'd8; valid0 = 1'b1;
    tick();
    data0 = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b2b_bit%0d", i), bit0, stream[15-i]);
      check($sformatf("b2b_valid%0d", i), bit_valid0, 1);
      check($sformatf("b2b_done%0d", i), done0, (i == 7) || (i == 15));
      if (i == 7) check("b2b_ready_last", ready0, 1);
      if (i == 3) check("b2b_ready_mid", ready0, 0);
      tick();
      if (i == 7) valid0 = 1'b0;
    end
    check("b2b_idle_valid", bit_valid0, 0);
    check("b2b_idle_busy", busy0, 0);

    // GAP=0: twenty ones in one burst, then 0,1,1
    rst0_n = 1'b0;
    tick();
    rst0_n = 1'b1;
    tick();
    data0 = 8'hFF; len0 = 4'd0; valid0 = 1'b1;
    tick();
    for (int i = 0; i < 23; i++) begin
      check($sformatf("burst_bit%0d", i), bit0, (i != 20));
      check($sformatf("burst_valid%0d", i), bit_valid0, 1);
      check($sformatf("burst_done%0d", i), done0,
            (i == 7) || (i == 15) || (i == 19) || (i == 22));
      if (i == 20) check("burst_cnt20", exp_cnt0, EXP_EN ? 18 : 0);
      tick();
      if (i == 7)  begin data0 = 8'h0F; len0 = 4'd4; end
      if (i == 15) begin data0 = 8'h03; len0 = 4'd3; end
      if (i == 19) valid0 = 1'b0;
    end
    check("burst_idle_valid", bit_valid0, 0);
    check("burst_cnt_final", exp_cnt0, EXP_EN ? 18 : 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pattern_serializer_tx.md
Name: pattern_serializer_tx

Overview:
- Parallel-to-serial pattern transmitter. Accepts a word of up to WIDTH bits over a valid/ready handshake and emits it one bit per clock, MSB of the selected field first.
- Optionally inserts GAP zero bits after each word.
- Drives the serial input of the team's run/pattern detector FSMs for bring-up and self-test.

Parameters:
- WIDTH, 8, maximum bits per word.
- LEN_W, 4, width of len_i; must satisfy 2^LEN_W > WIDTH.
- GAP, 1, zero bits appended after each word (0 = none).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- data_i  input  WIDTH  word to send; field is data_i[len-1:0]
- len_i  input  LEN_W  bits to send; 0 or values above WIDTH mean WIDTH
- valid_i  input  1  word offered
- ready_o  output  1  word accepted at a rising edge when valid_i && ready_o
- bit_o  output  1  serial data bit (registered)
- bit_valid_o  output  1  bit_o is meaningful this cycle (registered)
- busy_o  output  1  high in SHIFT or GAP state
- done_o  output  1  one-cycle pulse coincident with the last data bit of a word
- expect_cnt_o  output  16  see Optional Feature

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - bit_o, bit_valid_o, busy_o, done_o and expect_cnt_o are 0; the shift register and counters are cleared.
  - ready_o is 0 while rst_n is low.
- States: IDLE, SHIFT, GAP.
- IDLE:
  - ready_o=1, bit_valid_o=0, bit_o=0.
  - On accept: latch the data field, set len_eff = clamp(len_i), go to SHIFT.
- Latency: accept at edge E. The first bit (data_i[len_eff-1]) appears on bit_o with bit_valid_o=1 in the cycle after E.
- SHIFT:
  - One bit per cycle, descending index, for exactly len_eff cycles.
  - done_o=1 during the last bit.
  - After the last bit, go to GAP if GAP>0, else to IDLE.
- GAP:
  - bit_o=0 and bit_valid_o=1 for exactly GAP cycles, then IDLE.
- Back-to-back streaming:
  - ready_o is also 1 in the last SHIFT cycle when GAP==0, and in the last GAP cycle when GAP>0.
  - An accept in that cycle reloads and goes directly to SHIFT, so bit_valid_o never drops between words.
- valid_i while ready_o=0 is ignored. data_i and len_i are sampled only at accept; later changes have no effect.
- len_eff=1: a single SHIFT cycle, with done_o in that cycle.
- The bit counter is LEN_W bits and counts down from len_eff-1 to 0, so it cannot wrap.
- busy_o = (state != IDLE).
- Reset mid-word aborts immediately: no done_o pulse, and the partial word is discarded.

Optional Feature:
- Macro: PATTERN_TX_EXPECT_EN.
- With the macro:
  - expect_cnt_o counts cycles where bit_valid_o=1, bit_o=1, and the two previous valid bits were both 1. This is overlapping detection of three consecutive ones.
  - The count equals the number of detect pulses a downstream run-of-three detector must produce.
  - The run history clears on any bit_valid_o=1 with bit_o=0 and on reset. IDLE cycles do not clear it.
  - The counter saturates at 16'hFFFF.
- Without the macro: expect_cnt_o is tied to 0 and no history logic is built.

Decomposition:
- Package pattern_tx_pkg:
  - State encodings IDLE=2'b00, SHIFT=2'b01, GAP=2'b10.
  - Default WIDTH, LEN_W and GAP constants.
  - RUN_LEN=3 for the expect model.
- Sub-module pattern_run_model: history shift register plus saturating counter. Instantiated only under PATTERN_TX_EXPECT_EN.

Test Plan:
- Reset, then data_i=8'hB5, len_i=0, GAP=1 -> bits 1,0,1,1,0,1,0,1 then one 0 on bit_o. done_o on the 8th bit. ready_o returns high on the gap cycle.
- len_i=3, data_i=8'hFF -> exactly 3 valid ones then gap. With the macro, expect_cnt_o=1.
- GAP=0, valid_i held high, words 8'hF0 then 8'h0F, len 8 -> 16 contiguous valid bits 11110000 00001111 with no bubble. done_o pulses at bits 8 and 16.
- len_i=12 with WIDTH=8 -> clamped to 8 bits. len_i=1, data=1 -> single bit 1 with done_o in the same cycle.
- Assert rst_n low during the 4th bit of a word -> outputs 0 immediately, no done_o, ready_o=1 one cycle after release, and a fresh word sends correctly.
- Macro on, stream of twenty 1s in one burst -> expect_cnt_o=18. A following 0 bit and then 1,1 leave the count at 18.
